// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

    // Next-pc source select, encoded exactly as driven by the control unit.
    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JALR   = 2'd2,
        TRAP   = 2'd3
    } pcsrc_t;

    // Sequential fetch increment (one 32-bit instruction).
    localparam int PC_INC = 4;

endpackage : pc_pkg

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// entry count. A push into a full stack silently overwrites the oldest entry.
// A push and a pop in the same cycle replace the top entry in place.
module pc_ras #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int RAS_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDRESS_WIDTH-1:0] push_data,
    output logic [ADDRESS_WIDTH-1:0] top,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESS_WIDTH-1:0] entries [RAS_DEPTH];
    logic [PW-1:0]            ptr;
    logic [CW-1:0]            count;
    logic                     pop_ok;

    assign empty  = (count == '0);
    assign full   = (count == CW'(RAS_DEPTH));
    assign top    = entries[ptr];
    // Popping an empty stack has no effect on pointer or count.
    assign pop_ok = pop && !empty;

    // Pointer and count bookkeeping; count saturates at depth on overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop_ok) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full)
                count <= count + CW'(1);
        end else if (pop_ok) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && pop_ok)
            entries[ptr] <= push_data;
        else if (push)
            entries[ptr + PW'(1)] <= push_data;
    end

endmodule : pc_ras

// File: rtl/pc_gen.sv
// Program-counter generator at the head of fetch: four-way next-pc select,
// stall hold, misaligned-redirect trapping and a return-address stack used
// as a prediction source for JALR returns.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                     RAS_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [1:0]               PCsrc,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic [DATA_WIDTH-1:0]    rs1,
    input  logic [ADDRESS_WIDTH-1:0] trap_vector,
    input  logic                     ras_push,
    input  logic                     ras_pop,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic                     misaligned,
    output logic                     ras_empty,
    output logic                     ras_full
);

    logic [ADDRESS_WIDTH-1:0] imm_a;
    logic [ADDRESS_WIDTH-1:0] rs1_a;
    logic [ADDRESS_WIDTH-1:0] branch_tgt;
    logic [ADDRESS_WIDTH-1:0] jalr_tgt;
    logic [ADDRESS_WIDTH-1:0] ras_top;
    logic [ADDRESS_WIDTH-1:0] target;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic                     use_ras;
    logic                     check_align;
    logic                     mis_target;
    logic                     push_en;
    logic                     pop_en;

    // Operands are sign-extended or truncated to the address width.
    assign imm_a = ADDRESS_WIDTH'($signed(ImmOp));
    assign rs1_a = ADDRESS_WIDTH'($signed(rs1));

    // Candidate targets and RAS control; all adds wrap modulo 2^ADDRESS_WIDTH.
    always_comb begin
        pc_plus4    = pc + ADDRESS_WIDTH'(PC_INC);
        branch_tgt  = pc + imm_a;
        jalr_tgt    = (rs1_a + imm_a) & ~ADDRESS_WIDTH'(1);
        use_ras     = 1'b0;
        check_align = 1'b0;
        target      = pc_plus4;
        case (pcsrc_t'(PCsrc))
            SEQ:    target = pc_plus4;
            BRANCH: begin
                target      = branch_tgt;
                check_align = 1'b1;
            end
            JALR: begin
                use_ras     = ras_pop && !ras_empty;
                target      = use_ras ? ras_top : jalr_tgt;
                check_align = 1'b1;
            end
            TRAP:   target = trap_vector;
            default: target = pc_plus4;
        endcase
        // Only bit 1 is checked; JALR already clears bit 0.
        mis_target = check_align && target[1];
        pc_next    = mis_target ? trap_vector : target;
        push_en    = ras_push && !stall && !mis_target;
        pop_en     = use_ras && !stall && !mis_target;
    end

    // PC and misaligned-pulse registers; stall freezes pc and masks the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else begin
            misaligned <= !stall && mis_target;
            if (!stall)
                pc <= pc_next;
        end
    end

    pc_ras #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RAS_DEPTH     (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .pop       (pop_en),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with RESET_VECTOR=0x100, RAS_DEPTH=4.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  PCsrc;
    logic [31:0] ImmOp;
    logic [31:0] rs1;
    logic [31:0] trap_vector;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        ras_empty;
    logic        ras_full;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] S_SEQ = 2'd0, S_BR = 2'd1, S_JALR = 2'd2, S_TRAP = 2'd3;
    localparam logic [31:0] TVEC = 32'h80;

    pc_gen #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_VECTOR  (32'h100),
        .RAS_DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp),
        .rs1         (rs1),
        .trap_vector (trap_vector),
        .ras_push    (ras_push),
        .ras_pop     (ras_pop),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misaligned  (misaligned),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, clock, and settle 1 time unit past the edge.
    task automatic step(input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] r1, input logic push,
                        input logic pop, input logic stl);
        PCsrc = src; ImmOp = imm; rs1 = r1;
        ras_push = push; ras_pop = pop; stall = stl;
        @(posedge clk);
        #1;
    endtask

    // Load an arbitrary pc through the (unchecked) trap path.
    task automatic set_pc(input logic [31:0] v);
        trap_vector = v;
        step(S_TRAP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        trap_vector = TVEC;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        rst = 1'b0; stall = 1'b0; PCsrc = S_SEQ; ImmOp = '0; rs1 = '0;
        trap_vector = TVEC; ras_push = 1'b0; ras_pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (pc !== 32'h100) begin $display("FAIL reset_pc: got %h want %h", pc, 32'h100); fails++; end
        tests++; if (misaligned !== 1'b0) begin $display("FAIL reset_mis: got %b want 0", misaligned); fails++; end
        tests++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            $display("FAIL reset_ras: empty=%b full=%b want 1 0", ras_empty, ras_full); fails++; end
        rst = 1'b1;
        exp_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step(S_SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            exp_pc = exp_pc + 32'h4;
            tests++; if (pc !== exp_pc) begin $display("FAIL seq_%0d: got %h want %h", i, pc, exp_pc); fails++; end
        end
        tests++; if (pc_plus4 !== 32'h110) begin $display("FAIL pc_plus4: got %h want %h", pc_plus4, 32'h110); fails++; end
        tests++; if (ras_empty !== 1'b1) begin $display("FAIL seq_empty: got %b want 1", ras_empty); fails++; end
    endtask

    task automatic test_branch();
        set_pc(32'h200);
        tests++; if (pc !== 32'h200) begin $display("FAIL trap_load: got %h want %h", pc, 32'h200); fails++; end
        step(S_BR, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 32'h1F8 || misaligned !== 1'b0) begin
            $display("FAIL branch_back: pc=%h mis=%b want 1f8 0", pc, misaligned); fails++; end
        step(S_BR, 32'h6, 32'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== TVEC || misaligned !== 1'b1) begin
            $display("FAIL branch_mis: pc=%h mis=%b want 80 1", pc, misaligned); fails++; end
        step(S_SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 32'h84 || misaligned !== 1'b0) begin
            $display("FAIL mis_pulse: pc=%h mis=%b want 84 0", pc, misaligned); fails++; end
        // A misaligned redirect must not push even when ras_push is set.
        step(S_BR, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
        tests++; if (pc !== TVEC || misaligned !== 1'b1 || ras_empty !== 1'b1) begin
            $display("FAIL mis_nopush: pc=%h mis=%b empty=%b want 80 1 1", pc, misaligned, ras_empty); fails++; end
    endtask

    task automatic test_jalr_stall();
        set_pc(32'h300);
        step(S_JALR, 32'h0, 32'h1001, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 32'h1000 || misaligned !== 1'b0) begin
            $display("FAIL jalr_bit0: pc=%h mis=%b want 1000 0", pc, misaligned); fails++; end
        for (int i = 0; i < 2; i++) begin
            step(S_BR, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1);
            tests++; if (pc !== 32'h1000) begin $display("FAIL stall_%0d: got %h want %h", i, pc, 32'h1000); fails++; end
        end
        tests++; if (ras_empty !== 1'b1) begin $display("FAIL stall_nopush: empty=%b want 1", ras_empty); fails++; end
        step(S_BR, 32'h6, 32'h0, 1'b0, 1'b0, 1'b1);
        tests++; if (pc !== 32'h1000 || misaligned !== 1'b0) begin
            $display("FAIL stall_mis: pc=%h mis=%b want 1000 0", pc, misaligned); fails++; end
        step(S_JALR, 32'h10, 32'h2000, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 32'h2010) begin $display("FAIL jalr_add: got %h want %h", pc, 32'h2010); fails++; end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_pop [4];
        exp_pop[0] = 32'h54; exp_pop[1] = 32'h44; exp_pop[2] = 32'h34; exp_pop[3] = 32'h24;
        for (int i = 1; i <= 5; i++) begin
            set_pc(32'h10 * i);
            step(S_SEQ, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            if (i == 3) begin
                tests++; if (ras_full !== 1'b0 || ras_empty !== 1'b0) begin
                    $display("FAIL ras_partial: full=%b empty=%b want 0 0", ras_full, ras_empty); fails++; end
            end
        end
        tests++; if (ras_full !== 1'b1) begin $display("FAIL ras_full: got %b want 1", ras_full); fails++; end
        for (int i = 0; i < 4; i++) begin
            step(S_JALR, 32'h0, 32'h5000, 1'b0, 1'b1, 1'b0);
            tests++; if (pc !== exp_pop[i]) begin $display("FAIL ras_pop_%0d: got %h want %h", i, pc, exp_pop[i]); fails++; end
        end
        tests++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            $display("FAIL ras_drained: empty=%b full=%b want 1 0", ras_empty, ras_full); fails++; end
        step(S_JALR, 32'h4, 32'h5000, 1'b0, 1'b1, 1'b0);
        tests++; if (pc !== 32'h5004 || ras_empty !== 1'b1) begin
            $display("FAIL ras_underflow: pc=%h empty=%b want 5004 1", pc, ras_empty); fails++; end
    endtask

    task automatic test_push_pop();
        set_pc(32'h10);
        step(S_SEQ, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        set_pc(32'h60);
        step(S_JALR, 32'h0, 32'h3000, 1'b1, 1'b1, 1'b0);
        tests++; if (pc !== 32'h14) begin $display("FAIL replace_tgt: got %h want %h", pc, 32'h14); fails++; end
        tests++; if (ras_empty !== 1'b0 || ras_full !== 1'b0) begin
            $display("FAIL replace_cnt: empty=%b full=%b want 0 0", ras_empty, ras_full); fails++; end
        // Pop with SEQ selected is ignored.
        step(S_SEQ, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tests++; if (pc !== 32'h18 || ras_empty !== 1'b0) begin
            $display("FAIL seq_nopop: pc=%h empty=%b want 18 0", pc, ras_empty); fails++; end
        step(S_JALR, 32'h0, 32'h3000, 1'b0, 1'b1, 1'b0);
        tests++; if (pc !== 32'h64 || ras_empty !== 1'b1) begin
            $display("FAIL replace_top: pc=%h empty=%b want 64 1", pc, ras_empty); fails++; end
    endtask

    task automatic test_wrap_async_reset();
        set_pc(32'hFFFF_FFFC);
        step(S_SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 32'h0) begin $display("FAIL seq_wrap: got %h want 0", pc); fails++; end
        step(S_BR, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0);
        tests++; if (pc !== 32'hFFFF_FFFC || ras_empty !== 1'b0) begin
            $display("FAIL branch_wrap: pc=%h empty=%b want fffffffc 0", pc, ras_empty); fails++; end
        PCsrc = S_BR; ImmOp = 32'h40; stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        tests++; if (pc !== 32'h100 || ras_empty !== 1'b1 || misaligned !== 1'b0) begin
            $display("FAIL async_reset: pc=%h empty=%b mis=%b want 100 1 0", pc, ras_empty, misaligned); fails++; end
        @(posedge clk);
        #1;
        tests++; if (pc !== 32'h100) begin $display("FAIL reset_hold: got %h want %h", pc, 32'h100); fails++; end
        stall = 1'b0; PCsrc = S_SEQ;
        rst = 1'b1;
        step(S_SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 32'h104) begin $display("FAIL post_reset: got %h want %h", pc, 32'h104); fails++; end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr_stall();
        test_ras_overflow();
        test_push_pop();
        test_wrap_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pc_gen

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator replacing the two-way sequential/branch PC path with a four-source next-PC selector, stall hold, misaligned-target trapping and a small return-address stack (RAS). Sits at the head of the fetch stage: drives the instruction-memory address and receives redirect controls from the decode/execute control unit.

## Interface

Parameters:
- ADDRESS_WIDTH, 32, width of pc and all address arithmetic
- DATA_WIDTH, 32, width of ImmOp and rs1
- RESET_VECTOR, 0, pc value loaded on reset
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  hold pc and RAS this cycle
- PCsrc  input  2  next-pc select: SEQ=0, BRANCH=1, JALR=2, TRAP=3
- ImmOp  input  DATA_WIDTH  sign-extended immediate
- rs1  input  DATA_WIDTH  jalr base register value
- trap_vector  input  ADDRESS_WIDTH  trap handler address
- ras_push  input  1  call: push pc+4
- ras_pop  input  1  return hint: use RAS top for JALR
- pc  output  ADDRESS_WIDTH  current fetch address
- pc_plus4  output  ADDRESS_WIDTH  pc+4 (combinational, link value)
- misaligned  output  1  one-cycle pulse: last redirect target was misaligned
- ras_empty  output  1  RAS holds no entries
- ras_full  output  1  RAS holds RAS_DEPTH entries

## Operation

- Target: SEQ→pc+4; BRANCH→pc+ImmOp; JALR→(rs1+ImmOp) with bit0 cleared; TRAP→trap_vector.
- JALR with ras_pop=1 and RAS non-empty: target is RAS top, entry popped. RAS empty: computed jalr target used, count stays 0.
- ImmOp/rs1 truncated or sign-extended to ADDRESS_WIDTH; all adds modulo 2^ADDRESS_WIDTH (wrap, no flag).
- Misalignment: BRANCH or JALR target with bit1≠0 → pc loads trap_vector instead, misaligned=1 next cycle; no RAS push/pop takes effect that cycle.
- ras_push: pushes pc_plus4. Push when full: overwrites oldest (circular), count saturates at RAS_DEPTH, ras_full stays 1.
- Push and effective pop same cycle: top entry replaced with pc_plus4, count unchanged.
- ras_push/ras_pop ignored when PCsrc is SEQ or TRAP for pop; push honoured with any PCsrc except on misalignment.
- stall=1: pc, RAS and count hold; misaligned forced 0; all other inputs ignored.
- TRAP has no misalignment check.

## Timing

- Reset (asserted, async): pc=RESET_VECTOR, misaligned=0, RAS count=0 (ras_empty=1, ras_full=0). Entries need not be cleared.
- Reset released: first pc update on the first rising edge with rst=1.
- Next-pc and RAS top are combinational from current state/inputs; pc updates one edge after PCsrc presented (latency 1).
- pc_plus4, ras_empty, ras_full are combinational from registered state.
- misaligned registered; high exactly one cycle per offending redirect.
- Reset mid-stall or mid-redirect: reset wins immediately.

## Structure

- Package pc_pkg: pcsrc_t enum (SEQ, BRANCH, JALR, TRAP), PC_INC=4 constant.
- Sub-module pc_ras: RAS_DEPTH×ADDRESS_WIDTH circular buffer, top pointer, saturating count, push/pop/replace, empty/full.
- pc_gen: target muxing, alignment check, pc and misaligned registers.

## Test plan

- Reset with RESET_VECTOR=0x100, then 3 cycles SEQ → pc 0x100, 0x104, 0x108, 0x10C; ras_empty=1.
- pc=0x200, BRANCH, ImmOp=-8 → pc=0x1F8; ImmOp=0x6 → pc=trap_vector (0x80), misaligned=1 for one cycle.
- pc=0x300, JALR rs1=0x1001 ImmOp=0 → pc=0x1000; stall=1 for 2 cycles with PCsrc=BRANCH → pc stays 0x1000.
- RAS_DEPTH=4: five pushes from pc 0x10,0x20,0x30,0x40,0x50 → ras_full=1; four JALR+ras_pop → pc 0x54,0x44,0x34,0x24; fifth pop → computed jalr target, ras_empty=1.
- One entry 0x14, JALR+ras_pop+ras_push at pc=0x60 → pc=0x14, top becomes 0x64, count stays 1.
- pc=0xFFFFFFFC, SEQ → pc=0x0 (wrap); assert rst low mid-cycle → pc=RESET_VECTOR asynchronously.
